// File: rtl/myproject_mul_pkg.sv
// rtl/myproject_mul_pkg.sv - shared widths and clamp bounds for the pipelined multiplier
//
// Contents:
//   MAX_STAGE   deepest supported pipeline
//   MAX_PW      widest full product (32 + 32 + 2 bits)
//   prod_width  full signed product width for two operand widths
//   sat_max     upper clamp bound for a result width and signedness
//   sat_min     lower clamp bound for a result width and signedness
package myproject_mul_pkg;

    localparam int MAX_STAGE = 4;
    localparam int MAX_PW    = 66;

    // Each operand grows by one bit so signed and unsigned operands share
    // a single signed multiplier.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    function automatic logic signed [MAX_PW-1:0] sat_max(input int width, input bit signed_out);
        logic signed [MAX_PW-1:0] one;
        one = {{(MAX_PW-1){1'b0}}, 1'b1};
        if (signed_out) begin
            return (one << (width - 1)) - one;
        end
        return (one << width) - one;
    endfunction

    function automatic logic signed [MAX_PW-1:0] sat_min(input int width, input bit signed_out);
        logic signed [MAX_PW-1:0] one;
        one = {{(MAX_PW-1){1'b0}}, 1'b1};
        if (signed_out) begin
            return -(one << (width - 1));
        end
        return '0;
    endfunction

endpackage

// File: rtl/myproject_pipe_slot.sv
// rtl/myproject_pipe_slot.sv - one valid/data register slot of an elastic pipeline
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (clears valid only)
//   up_valid_i      upstream offers a beat
//   up_data_i       upstream beat data
//   down_ready_i    downstream slot is empty or advancing (or sink ready)
//   valid_o         slot holds a beat
//   data_o          held beat data
module myproject_pipe_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic              down_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              accept;
    logic              load;

    always_comb begin
        // The slot can take a new beat when empty or when its current
        // beat leaves in the same cycle, so bubbles collapse.
        accept  = !valid_q || down_ready_i;
        load    = up_valid_i && accept;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
        end else if (down_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/myproject_mul_pipe.sv
// rtl/myproject_mul_pipe.sv - pipelined multiplier with per-beat signedness and wrap/clamp output
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready        operand beat handshake
//   din0, din1                operands
//   din0_signed, din1_signed  1 = operand is two's complement
//   out_valid, out_ready      result handshake
//   dout                      truncated or clamped product
//   dout_sat                  clamp changed the value
module myproject_mul_pipe
    import myproject_mul_pkg::*;
#(
    parameter int DIN0_WIDTH     = 14,
    parameter int DIN1_WIDTH     = 12,
    parameter int DOUT_WIDTH     = 26,
    parameter int NUM_STAGE      = 2,
    parameter int SATURATE       = 0,
    parameter int SAT_SIGNED_OUT = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_sat
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int E0 = DIN0_WIDTH + 1;
    localparam int E1 = DIN1_WIDTH + 1;

    localparam logic signed [MAX_PW-1:0] SAT_HI = sat_max(DOUT_WIDTH, SAT_SIGNED_OUT != 0);
    localparam logic signed [MAX_PW-1:0] SAT_LO = sat_min(DOUT_WIDTH, SAT_SIGNED_OUT != 0);

    logic [E0-1:0]           ext0;
    logic [E1-1:0]           ext1;
    logic [NUM_STAGE-1:0]    slot_valid;
    logic [NUM_STAGE:0]      rdy_chain;
    logic signed [PW-1:0]    fin_src;
    logic                    fin_src_valid;
    logic signed [MAX_PW-1:0] fin_wide;
    logic [DOUT_WIDTH-1:0]   res;
    logic                    res_sat;
    logic [DOUT_WIDTH:0]     fin_q;

    // Extension bit is the operand MSB only for signed operands.
    assign ext0 = {din0_signed & din0[DIN0_WIDTH-1], din0};
    assign ext1 = {din1_signed & din1[DIN1_WIDTH-1], din1};

    // rdy_chain[i] = slot i may load this cycle (empty or advancing).
    // Built in one process so the backward ready path stays a plain
    // combinational chain from out_ready to in_ready.
    always_comb begin
        rdy_chain            = '0;
        rdy_chain[NUM_STAGE] = out_ready;
        for (int i = NUM_STAGE - 1; i >= 0; i--) begin
            rdy_chain[i] = !slot_valid[i] || rdy_chain[i+1];
        end
    end

    assign in_ready = rdy_chain[0];

    if (NUM_STAGE > 1) begin : g_multi
        // Slot 0 holds {ext0, ext1}; later non-final slots hold the product.
        logic [PW-1:0]        mid_q [NUM_STAGE-1];
        logic signed [PW-1:0] mul_p;

        assign mul_p = PW'($signed(mid_q[0][PW-1 -: E0])) * PW'($signed(mid_q[0][E1-1:0]));

        for (genvar i = 0; i < NUM_STAGE - 1; i++) begin : g_slot
            logic [PW-1:0] up_data;
            logic          up_valid;

            if (i == 0) begin : g_ops
                assign up_data  = {ext0, ext1};
                assign up_valid = in_valid;
            end else if (i == 1) begin : g_mul
                assign up_data  = mul_p;
                assign up_valid = slot_valid[0];
            end else begin : g_copy
                assign up_data  = mid_q[i-1];
                assign up_valid = slot_valid[i-1];
            end

            myproject_pipe_slot #(
                .DATA_W(PW)
            ) u_slot (
                .clk_i       (ap_clk),
                .rst_ni      (ap_rst_n),
                .up_valid_i  (up_valid),
                .up_data_i   (up_data),
                .down_ready_i(rdy_chain[i+1]),
                .valid_o     (slot_valid[i]),
                .data_o      (mid_q[i])
            );
        end

        // With two stages the multiply feeds the final slot directly.
        assign fin_src       = (NUM_STAGE == 2) ? mul_p : $signed(mid_q[NUM_STAGE-2]);
        assign fin_src_valid = slot_valid[NUM_STAGE-2];
    end else begin : g_single
        assign fin_src       = PW'($signed(ext0)) * PW'($signed(ext1));
        assign fin_src_valid = in_valid;
    end

    // Wrap keeps the LSBs; clamp compares in the widest signed domain so
    // both signed and unsigned bounds fit without overflow.
    always_comb begin
        fin_wide = MAX_PW'(fin_src);
        res      = fin_src[DOUT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (SATURATE != 0) begin
            if (fin_wide > SAT_HI) begin
                res     = SAT_HI[DOUT_WIDTH-1:0];
                res_sat = 1'b1;
            end else if (fin_wide < SAT_LO) begin
                res     = SAT_LO[DOUT_WIDTH-1:0];
                res_sat = 1'b1;
            end
        end
    end

    myproject_pipe_slot #(
        .DATA_W(DOUT_WIDTH + 1)
    ) u_final (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .up_valid_i  (fin_src_valid),
        .up_data_i   ({res_sat, res}),
        .down_ready_i(rdy_chain[NUM_STAGE]),
        .valid_o     (slot_valid[NUM_STAGE-1]),
        .data_o      (fin_q)
    );

    // Data registers are unreset, so outputs are masked to zero when idle.
    assign out_valid = slot_valid[NUM_STAGE-1];
    assign dout      = out_valid ? fin_q[DOUT_WIDTH-1:0] : '0;
    assign dout_sat  = out_valid & fin_q[DOUT_WIDTH];

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// tb/tb_myproject_mul_pipe.sv - directed self-checking bench for myproject_mul_pipe
module tb_myproject_mul_pipe;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_s0, a_s1, a_out_valid, a_out_ready, a_sat;
    logic [13:0] a_din0;
    logic [11:0] a_din1;
    logic [25:0] a_dout;

    logic        b_in_valid, b_in_ready, b_s0, b_s1, b_out_valid, b_out_ready, b_sat;
    logic [13:0] b_din0;
    logic [11:0] b_din1;
    logic [7:0]  b_dout;

    int checks;
    int failures;

    myproject_mul_pipe dut_a (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .din0       (a_din0),
        .din1       (a_din1),
        .din0_signed(a_s0),
        .din1_signed(a_s1),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .dout       (a_dout),
        .dout_sat   (a_sat)
    );

    myproject_mul_pipe #(
        .DOUT_WIDTH    (8),
        .NUM_STAGE     (3),
        .SATURATE      (1),
        .SAT_SIGNED_OUT(1)
    ) dut_b (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .din0       (b_din0),
        .din1       (b_din1),
        .din0_signed(b_s0),
        .din1_signed(b_s1),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .dout       (b_dout),
        .dout_sat   (b_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_din0 = '0; a_din1 = '0; a_s0 = 0; a_s1 = 0; a_out_ready = 1;
        b_in_valid = 0; b_din0 = '0; b_din1 = '0; b_s0 = 0; b_s1 = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_a_out_valid got=%0b exp=0", a_out_valid); end
        checks++; if (a_dout !== 26'd0) begin failures++; $display("FAIL reset_a_dout got=%h exp=0", a_dout); end
        checks++; if (a_sat !== 1'b0) begin failures++; $display("FAIL reset_a_sat got=%0b exp=0", a_sat); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%0b exp=0", b_out_valid); end
        checks++; if (b_dout !== 8'd0) begin failures++; $display("FAIL reset_b_dout got=%h exp=0", b_dout); end
        checks++; if (b_sat !== 1'b0) begin failures++; $display("FAIL reset_b_sat got=%0b exp=0", b_sat); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_a_in_ready got=%0b exp=1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%0b exp=1", b_in_ready); end
    endtask

    task automatic test_product();
        logic [13:0] t0 [5];
        logic [11:0] t1 [5];
        logic        ts0 [5];
        logic        ts1 [5];
        logic [25:0] te [5];
        t0  = '{14'h3FFF, 14'h3FFD, 14'h3FFE, 14'h3FFD, 14'h3FFF};
        t1  = '{12'hFFF, 12'h005, 12'hFFD, 12'h005, 12'h800};
        ts0 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ts1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        te  = '{26'h3FFB001, 26'h3FFFFF1, 26'h0000006, 26'h0013FF1, 26'h2000800};
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            a_in_valid = 1; a_din0 = t0[v]; a_din1 = t1[v]; a_s0 = ts0[v]; a_s1 = ts1[v]; a_out_ready = 1;
            @(negedge clk);
            checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL prod_in_ready v=%0d got=%0b exp=1", v, a_in_ready); end
            @(posedge clk); #1;
            a_in_valid = 0;
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL prod_early v=%0d got=%0b exp=0", v, a_out_valid); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL prod_valid v=%0d got=%0b exp=1", v, a_out_valid); end
            checks++; if (a_dout !== te[v]) begin failures++; $display("FAIL prod_dout v=%0d got=%h exp=%h", v, a_dout, te[v]); end
            checks++; if (a_sat !== 1'b0) begin failures++; $display("FAIL prod_sat v=%0d got=%0b exp=0", v, a_sat); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        logic [13:0] t0 [9];
        logic [11:0] t1 [9];
        logic        ts0 [9];
        logic        ts1 [9];
        logic [7:0]  te [9];
        logic        tsat [9];
        t0   = '{14'd100, 14'h3FEC, 14'd3, 14'd127, 14'h3F80, 14'd128, 14'h3F7F, 14'h3FEC, 14'h3FFD};
        t1   = '{12'd100, 12'd10, 12'd4, 12'd1, 12'd1, 12'd1, 12'd1, 12'd10, 12'hFFB};
        ts0  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ts1  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        te   = '{8'h7F, 8'h80, 8'h0C, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h0F};
        tsat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            b_in_valid = 1; b_din0 = t0[v]; b_din1 = t1[v]; b_s0 = ts0[v]; b_s1 = ts1[v]; b_out_ready = 1;
            @(posedge clk); #1;
            b_in_valid = 0;
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL sat_early1 v=%0d got=%0b exp=0", v, b_out_valid); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL sat_early2 v=%0d got=%0b exp=0", v, b_out_valid); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid v=%0d got=%0b exp=1", v, b_out_valid); end
            checks++; if (b_dout !== te[v]) begin failures++; $display("FAIL sat_dout v=%0d got=%h exp=%h", v, b_dout, te[v]); end
            checks++; if (b_sat !== tsat[v]) begin failures++; $display("FAIL sat_flag v=%0d got=%0b exp=%0b", v, b_sat, tsat[v]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int          pat [4];
        int          sent;
        int          rx;
        int          count;
        bit          xi;
        bit          xo;
        bit          prev_stall;
        logic [25:0] prev_dout;
        logic        exp_ready;
        pat = '{1, 0, 0, 1};
        sent = 0; rx = 0; count = 0; xi = 0; xo = 0; prev_stall = 0; prev_dout = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            if (xi) sent++;
            count = count + int'(xi) - int'(xo);
            #1;
            a_out_ready = (pat[cyc % 4] != 0);
            a_in_valid  = (sent < 10);
            a_din0      = 14'(sent + 1);
            a_din1      = 12'd2;
            a_s0 = 0; a_s1 = 0;
            @(negedge clk);
            exp_ready = !(count == 2 && !a_out_ready);
            checks++; if (a_in_ready !== exp_ready) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=%0b", cyc, a_in_ready, exp_ready); end
            if (prev_stall) begin
                checks++; if (a_out_valid !== 1'b1 || a_dout !== prev_dout) begin failures++; $display("FAIL bp_stable cyc=%0d got=%0b/%h exp=1/%h", cyc, a_out_valid, a_dout, prev_dout); end
            end
            xi = a_in_valid && a_in_ready;
            xo = a_out_valid && a_out_ready;
            if (xo) begin
                checks++; if (a_dout !== 26'(2 * (rx + 1))) begin failures++; $display("FAIL bp_order rx=%0d got=%0d exp=%0d", rx, a_dout, 2 * (rx + 1)); end
                rx++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_dout  = a_dout;
        end
        checks++; if (rx != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", rx); end
        a_in_valid = 0; a_out_ready = 1;
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int n = 0; n < 104; n++) begin
            @(posedge clk); #1;
            a_out_ready = 1;
            a_in_valid  = (n < 100);
            a_din0      = 14'(n + 1);
            a_din1      = 12'd3;
            a_s0 = 0; a_s1 = 0;
            @(negedge clk);
            if (n < 100) begin
                checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready n=%0d got=%0b exp=1", n, a_in_ready); end
            end
            exp_v = (n >= 2 && n < 102);
            checks++; if (a_out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid n=%0d got=%0b exp=%0b", n, a_out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (a_dout !== 26'(3 * (n - 1))) begin failures++; $display("FAIL b2b_dout n=%0d got=%0d exp=%0d", n, a_dout, 3 * (n - 1)); end
            end
        end
        a_in_valid = 0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        a_out_ready = 0; a_in_valid = 1; a_din0 = 14'd7; a_din1 = 12'd1; a_s0 = 0; a_s1 = 0;
        @(posedge clk); #1;
        a_din0 = 14'd9;
        @(posedge clk); #1;
        a_in_valid = 0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1 || a_dout !== 26'd7) begin failures++; $display("FAIL rst_mid_setup got=%0b/%0d exp=1/7", a_out_valid, a_dout); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_full got=%0b exp=0", a_in_ready); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", a_out_valid); end
        checks++; if (a_dout !== 26'd0) begin failures++; $display("FAIL rst_mid_dout got=%h exp=0", a_dout); end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_stale i=%0d got=%0b exp=0", i, a_out_valid); end
        end
        @(posedge clk); #1;
        a_in_valid = 1; a_din0 = 14'd5; a_din1 = 12'd6;
        @(posedge clk); #1;
        a_in_valid = 0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_early got=%0b exp=0", a_out_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1 || a_dout !== 26'd30) begin failures++; $display("FAIL rst_mid_new got=%0b/%0d exp=1/30", a_out_valid, a_dout); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_product();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
